// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and types for the data-memory arbiter.
package dmem_arbiter_pkg;

  localparam int DMEM_ADDR_W = 10;
  localparam int DMEM_DATA_W = 32;

  localparam logic M_CPU = 1'b0;
  localparam logic M_AUX = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RETURN = 2'd2
  } arb_state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side signals of the arbiter; slave is the arbiter view.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);

  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [DATA_W-1:0] m1_rdata;

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data;
  logic              mem_rden;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  mem_q,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_address, mem_data, mem_rden, mem_wren
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output mem_q,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_address, mem_data, mem_rden, mem_wren
  );

endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-requester one-hot picker. DMEM_ARB_RR_EN selects round-robin on
// contention; otherwise requester 0 has fixed priority.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

`ifdef DMEM_ARB_RR_EN
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end
  end
`else
  logic unused_last;
  assign unused_last = last;

  always_comb begin
    gnt = 2'b00;
    if (req[0]) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-ported, one-cycle-latency data memory between two masters.
// Arbitration policy is set by DMEM_ARB_RR_EN (see rr_pick2).
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus,
  output logic           dbg_last,
  output arb_state_e     dbg_state
);

  logic [1:0]        req;
  logic [1:0]        pick;
  logic [1:0]        gnt;
  logic              any_gnt;
  logic              gnt_idx;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic last_d, last_q;
  logic rd_pend_d, rd_pend_q;
  logic rd_own_d, rd_own_q;

  assign req = {bus.m1_req, bus.m0_req};

  rr_pick2 u_pick (
    .req  (req),
    .last (last_q),
    .gnt  (pick)
  );

  // Grants are suppressed while reset is held so no write slips into memory.
  assign gnt     = rst ? 2'b00 : pick;
  assign any_gnt = |gnt;
  assign gnt_idx = gnt[M_AUX] ? M_AUX : M_CPU;

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (gnt[M_CPU]) begin
      sel_we    = bus.m0_we;
      sel_addr  = bus.m0_addr;
      sel_wdata = bus.m0_wdata;
    end else if (gnt[M_AUX]) begin
      sel_we    = bus.m1_we;
      sel_addr  = bus.m1_addr;
      sel_wdata = bus.m1_wdata;
    end
  end

  assign bus.m0_gnt      = gnt[M_CPU];
  assign bus.m1_gnt      = gnt[M_AUX];
  assign bus.mem_address = sel_addr;
  assign bus.mem_data    = sel_wdata;
  assign bus.mem_wren    = any_gnt & sel_we;
  assign bus.mem_rden    = any_gnt & ~sel_we;

  always_comb begin
    last_d    = any_gnt ? gnt_idx : last_q;
    rd_pend_d = any_gnt & ~sel_we;
    rd_own_d  = gnt_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q    <= 1'b1;
      rd_pend_q <= 1'b0;
      rd_own_q  <= 1'b0;
    end else begin
      last_q    <= last_d;
      rd_pend_q <= rd_pend_d;
      rd_own_q  <= rd_own_d;
    end
  end

  // Read data is steered to whichever master owned the previous-cycle read.
  assign bus.m0_rvalid = rd_pend_q & (rd_own_q == M_CPU);
  assign bus.m1_rvalid = rd_pend_q & (rd_own_q == M_AUX);
  assign bus.m0_rdata  = bus.m0_rvalid ? bus.mem_q : '0;
  assign bus.m1_rdata  = bus.m1_rvalid ? bus.mem_q : '0;

  always_comb begin
    dbg_state = IDLE;
    if (any_gnt) begin
      dbg_state = ACCESS;
    end else if (rd_pend_q) begin
      dbg_state = RETURN;
    end
  end

  assign dbg_last = last_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural one-cycle data memory.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  logic       clk;
  logic       rst;
  logic       dbg_last;
  arb_state_e dbg_state;

  dmem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus ();

  dmem_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_last  (dbg_last),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: unwritten words read back as 0xA0000000 | address.
  logic [31:0] mem     [0:1023];
  logic        written [0:1023];
  logic [31:0] mem_q_r;
  assign bus.mem_q = mem_q_r;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) written[i] <= 1'b0;
    end else begin
      if (bus.mem_wren) begin
        mem[bus.mem_address]     <= bus.mem_data;
        written[bus.mem_address] <= 1'b1;
      end
      if (bus.mem_rden) begin
        mem_q_r <= written[bus.mem_address] ? mem[bus.mem_address]
                                            : (32'hA000_0000 | {22'd0, bus.mem_address});
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        own;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];

  task automatic push(input logic own, input logic [31:0] data);
    exp_t e;
    e.own  = own;
    e.data = data;
    e.due  = cyc + 1;
    sb.push_back(e);
  endtask

  // Monitor: pops one expectation per returned read, checks owner, data, latency.
  always @(negedge clk) begin
    exp_t e;
    if (bus.m0_rvalid && bus.m1_rvalid) begin
      n_assert++;
      n_fail++;
      $display("FAIL both_rvalid: got 1 expected 0 (t=%0t)", $time);
    end else if (bus.m0_rvalid || bus.m1_rvalid) begin
      if (sb.size() == 0) begin
        n_assert++;
        n_fail++;
        $display("FAIL unexpected_rvalid: got m0=%0b m1=%0b expected none (t=%0t)",
                 bus.m0_rvalid, bus.m1_rvalid, $time);
      end else begin
        e = sb.pop_front();
        chk("rv_owner", {63'd0, bus.m1_rvalid}, {63'd0, e.own});
        chk("rdata", {32'd0, (bus.m1_rvalid ? bus.m1_rdata : bus.m0_rdata)}, {32'd0, e.data});
        chk("rv_latency", cyc, e.due);
      end
    end
    if (!bus.m0_rvalid) chk("m0_rdata_idle", {32'd0, bus.m0_rdata}, 64'd0);
    if (!bus.m1_rvalid) chk("m1_rdata_idle", {32'd0, bus.m1_rdata}, 64'd0);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic m, input logic req, input logic we,
                       input logic [9:0] addr, input logic [31:0] wdata);
    if (m == M_CPU) begin
      bus.m0_req = req; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata;
    end else begin
      bus.m1_req = req; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  logic exp_idx;

  initial begin
    rst = 1'b1;
    drive(M_CPU, 1'b1, 1'b0, 10'h010, 32'h0);
    drive(M_AUX, 1'b1, 1'b0, 10'h020, 32'h0);

    // Reset held with both masters requesting
    repeat (2) begin
      @(negedge clk);
      chk("rst_m0_gnt", {63'd0, bus.m0_gnt}, 64'd0);
      chk("rst_m1_gnt", {63'd0, bus.m1_gnt}, 64'd0);
      chk("rst_rden", {63'd0, bus.mem_rden}, 64'd0);
      chk("rst_wren", {63'd0, bus.mem_wren}, 64'd0);
      chk("rst_last", {63'd0, dbg_last}, 64'd1);
    end
    tick;
    rst = 1'b0;
    @(negedge clk);
    chk("rel_m0_gnt", {63'd0, bus.m0_gnt}, 64'd1);
    chk("rel_m1_gnt", {63'd0, bus.m1_gnt}, 64'd0);
    chk("rel_rden", {63'd0, bus.mem_rden}, 64'd1);
    chk("rel_addr", {54'd0, bus.mem_address}, 64'h010);
    push(M_CPU, 32'hA000_0010);
    tick;
    drive(M_CPU, 1'b0, 1'b0, 10'h0, 32'h0);
    chk("rel_last0", {63'd0, dbg_last}, 64'd0);
    @(negedge clk);
    chk("rel_m1_gnt2", {63'd0, bus.m1_gnt}, 64'd1);
    chk("rel_m0_gnt2", {63'd0, bus.m0_gnt}, 64'd0);
    push(M_AUX, 32'hA000_0020);
    tick;
    drive(M_AUX, 1'b0, 1'b0, 10'h0, 32'h0);
    chk("rel_last1", {63'd0, dbg_last}, 64'd1);

    // Contention: both masters hold reads for four cycles
    drive(M_CPU, 1'b1, 1'b0, 10'h030, 32'h0);
    drive(M_AUX, 1'b1, 1'b0, 10'h031, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
`ifdef DMEM_ARB_RR_EN
      exp_idx = k[0];
`else
      exp_idx = M_CPU;
`endif
      chk("cont_m0_gnt", {63'd0, bus.m0_gnt}, {63'd0, exp_idx == M_CPU});
      chk("cont_m1_gnt", {63'd0, bus.m1_gnt}, {63'd0, exp_idx == M_AUX});
      push(exp_idx, exp_idx ? 32'hA000_0031 : 32'hA000_0030);
      tick;
    end
    drive(M_CPU, 1'b0, 1'b0, 10'h0, 32'h0);
    drive(M_AUX, 1'b0, 1'b0, 10'h0, 32'h0);

    // m0 write then read of 0x005
    drive(M_CPU, 1'b1, 1'b1, 10'h005, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("wr_gnt", {63'd0, bus.m0_gnt}, 64'd1);
    chk("wr_wren", {63'd0, bus.mem_wren}, 64'd1);
    chk("wr_rden", {63'd0, bus.mem_rden}, 64'd0);
    chk("wr_addr", {54'd0, bus.mem_address}, 64'h005);
    chk("wr_data", {32'd0, bus.mem_data}, 64'hDEAD_BEEF);
    tick;
    drive(M_CPU, 1'b1, 1'b0, 10'h005, 32'h0);
    @(negedge clk);
    chk("rd_gnt", {63'd0, bus.m0_gnt}, 64'd1);
    chk("rd_wren", {63'd0, bus.mem_wren}, 64'd0);
    chk("rd_rden", {63'd0, bus.mem_rden}, 64'd1);
    push(M_CPU, 32'hDEAD_BEEF);
    tick;
    drive(M_CPU, 1'b0, 1'b0, 10'h0, 32'h0);
    @(negedge clk);
    chk("idle_rden", {63'd0, bus.mem_rden}, 64'd0);
    chk("idle_addr", {54'd0, bus.mem_address}, 64'd0);
    chk("state_return", {62'd0, dbg_state}, {62'd0, RETURN});
    tick;

    // Back-to-back m1 write to the top address, m0 read of it
    drive(M_AUX, 1'b1, 1'b1, 10'h3FF, 32'h0000_0001);
    @(negedge clk);
    chk("b2b_m1_gnt", {63'd0, bus.m1_gnt}, 64'd1);
    chk("b2b_wren", {63'd0, bus.mem_wren}, 64'd1);
    chk("b2b_addr", {54'd0, bus.mem_address}, 64'h3FF);
    tick;
    drive(M_AUX, 1'b0, 1'b0, 10'h0, 32'h0);
    drive(M_CPU, 1'b1, 1'b0, 10'h3FF, 32'h0);
    @(negedge clk);
    chk("b2b_m0_gnt", {63'd0, bus.m0_gnt}, 64'd1);
    chk("state_access", {62'd0, dbg_state}, {62'd0, ACCESS});
    push(M_CPU, 32'h0000_0001);
    tick;
    drive(M_CPU, 1'b0, 1'b0, 10'h0, 32'h0);
    tick;
    @(negedge clk);
    chk("state_idle", {62'd0, dbg_state}, {62'd0, IDLE});
    tick;

    // m1 read granted, reset pulsed in the following cycle
    drive(M_AUX, 1'b1, 1'b0, 10'h040, 32'h0);
    @(negedge clk);
    chk("rstrd_m1_gnt", {63'd0, bus.m1_gnt}, 64'd1);
    tick;
    drive(M_AUX, 1'b0, 1'b0, 10'h0, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("rstrd_m1_rvalid", {63'd0, bus.m1_rvalid}, 64'd0);
    chk("rstrd_last", {63'd0, dbg_last}, 64'd1);
    tick;
    rst = 1'b0;
    repeat (3) tick;

    chk("sb_empty", sb.size(), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-ported data memory between the processor load/store path (master 0) and a secondary requester such as a loader or debug/DMA engine (master 1). Each cycle it grants at most one request, drives the memory address, data and enable lines, and routes the one-cycle-latency read data back to the master that issued the read. It sits between the datapath's ALU-result/readData2 outputs and the `dataMemory` instance.

## Interface
- `ADDR_W`, default 10: word address width.
- `DATA_W`, default 32: data width.

- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `m0_req` in 1: master 0 request.
- `m0_we` in 1: master 0 write (1) or read (0).
- `m0_addr` in ADDR_W: master 0 address.
- `m0_wdata` in DATA_W: master 0 write data.
- `m0_gnt` out 1: master 0 granted this cycle.
- `m0_rvalid` out 1: master 0 read data valid.
- `m0_rdata` out DATA_W: master 0 read data.
- `m1_req`, `m1_we`, `m1_addr`, `m1_wdata`, `m1_gnt`, `m1_rvalid`, `m1_rdata`: same as the master 0 signals, for master 1.
- `mem_address` out ADDR_W: to data memory.
- `mem_data` out DATA_W: to data memory.
- `mem_rden` out 1: to data memory.
- `mem_wren` out 1: to data memory.
- `mem_q` in DATA_W: memory read data, valid one cycle after the `mem_rden` cycle.

## Operation
- Grant is combinational from the `req` inputs and the priority state. At most one `gnt` is high in any cycle.
- A granted request drives `mem_*` in the same cycle:
  - `mem_wren` = granted `we`; `mem_rden` = granted `~we`.
  - `mem_address` and `mem_data` come from the granted master.
- With no grant: `mem_rden` = `mem_wren` = 0, and `mem_address`/`mem_data` = 0.
- Handshake:
  - A master holds `req`, `we`, `addr` and `wdata` stable until it samples `gnt` = 1 at a rising edge.
  - The transfer completes in that cycle. The master may present a new request in the next cycle.
- Priority state `last` is 1 bit, reset value 1, so master 0 wins the first contention. On every grant, `last` ← granted index.
- Read tracking uses registers `rd_pend` (reset 0) and `rd_own` (reset 0):
  - Each cycle, `rd_pend` ← (grant & ~we) and `rd_own` ← granted index.
  - `mN_rvalid` = `rd_pend` & (`rd_own` == N).
  - `mN_rdata` = `mem_q` when `mN_rvalid` is high, else 0.
- Back-to-back grants are allowed, including a new grant while a read is returning, because the memory is pipelined.
- Named states, derived from `rd_pend` and the grant: IDLE (no grant, no pending read), ACCESS (grant this cycle), RETURN (pending read, no grant). ACCESS→ACCESS is legal.

## Timing
- Grant latency is 0 cycles: `req` at edge n−1 gives `gnt` in cycle n.
- Read data latency is 1 cycle: grant in cycle n gives `rvalid`/`rdata` in cycle n+1.
- Write takes effect at the memory edge in the grant cycle.
- Simultaneous requests: arbitration is as described under Configuration. The loser sees `gnt` = 0 and keeps waiting.
- Reset values:
  - All `gnt`, `rvalid` and `mem_*` enables are 0; `rdata` is 0.
  - `last` = 1, `rd_pend` = 0.
- Reset asserted mid-operation: a pending read is dropped and no `rvalid` is issued after reset releases.
- Reset with `req` held: grant resumes in the first cycle after deassertion.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin. On contention, grant the master that is not `last`. Worst-case wait is 1 cycle.
- `DMEM_ARB_RR_EN` undefined: fixed priority, master 0 always wins. `last` is still maintained for visibility but does not affect grants. Master 1 can starve.

## Structure
- The shared package holds:
  - `DMEM_ADDR_W` = 10 and `DMEM_DATA_W` = 32.
  - Master index constants `M_CPU` = 0 and `M_AUX` = 1.
  - An enum for the IDLE/ACCESS/RETURN state encoding.
- One sub-module, `rr_pick2`: a combinational two-requester picker taking `req[1:0]` and `last` and returning a one-hot grant. The macro selects its policy.

## Test plan
- Reset with both `req` high: no `gnt` during reset. After release, `m0_gnt` is high first and `last` = 0.
- m0 write addr 0x005 data 0xDEADBEEF, then m0 read 0x005: `mem_wren` 1 for one cycle, then `m0_rvalid` 1 with `m0_rdata` = 0xDEADBEEF one cycle after the read grant; `m1_rvalid` stays 0.
- Both masters hold reads for 4 cycles with `DMEM_ARB_RR_EN` defined: grants go m0, m1, m0, m1. Each `rvalid` lands on the correct master in the following cycle.
- The same stimulus with the macro undefined: `m0_gnt` on all 4 cycles and `m1_gnt` = 0 throughout.
- m1 read granted in cycle n, `rst` pulsed in cycle n+1 before the edge: no `m1_rvalid` at any time.
- Back-to-back m1 write 0x3FF ← 0x1, m0 read 0x3FF: read returns 0x00000001 one cycle after its grant, confirming the wrap-free top address.
